// File: rtl/pong_datapath.sv
// Pong datapath: serve/delay timer, level-scaled ball-step timer, hit/level tracking, scoring.
// All registered outputs update one edge after their controls; game_over/winner are combinational.
module pong_datapath #(
    parameter int T5_MAX    = 5,
    parameter int T20_BASE  = 20,
    parameter int WIN_SCORE = 7
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       T5_en,
    input  logic       T5_rst,
    input  logic       T20_en,
    input  logic       T20_rst,
    input  logic       Hit_ld,
    input  logic       Hit_clr,
    input  logic       Lvl_clr,
    input  logic       P1_ld,
    input  logic       P1_clr,
    input  logic       P2_ld,
    input  logic       P2_clr,
    output logic       T5_in,
    output logic       T20_tick,
    output logic [3:0] hit_count,
    output logic [1:0] level,
    output logic [3:0] P1_score,
    output logic [3:0] P2_score,
    output logic       game_over,
    output logic       winner
);

    localparam logic [15:0] T5_LIM   = 16'(T5_MAX);
    localparam logic [15:0] T20_LIM  = 16'(T20_BASE);
    localparam logic [3:0]  WIN_VAL  = 4'(WIN_SCORE);

    logic [15:0] t5_count;
    logic [15:0] t5_next;
    logic [15:0] t20_count;
    logic [15:0] period;
    logic [15:0] period_m1;
    logic        p1_win;
    logic        p2_win;
    logic        p1_inc;
    logic        p2_inc;
    logic        lvl_inc;

    always_comb begin
        t5_next = (t5_count >= T5_LIM) ? T5_LIM : t5_count + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            t5_count <= 16'd0;
            T5_in    <= 1'b0;
        end else if (T5_rst) begin
            t5_count <= 16'd0;
            T5_in    <= 1'b0;
        end else if (T5_en) begin
            t5_count <= t5_next;
            T5_in    <= (t5_next == T5_LIM);
        end
    end

    // Period shrinks immediately on a level change; >= catches a count already past it.
    always_comb begin
        period    = T20_LIM >> level;
        period_m1 = period - 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            t20_count <= 16'd0;
            T20_tick  <= 1'b0;
        end else if (T20_rst) begin
            t20_count <= 16'd0;
            T20_tick  <= 1'b0;
        end else if (T20_en) begin
            if (t20_count >= period_m1) begin
                t20_count <= 16'd0;
                T20_tick  <= 1'b1;
            end else begin
                t20_count <= t20_count + 16'd1;
                T20_tick  <= 1'b0;
            end
        end else begin
            T20_tick <= 1'b0;
        end
    end

    always_comb begin
        lvl_inc = Hit_ld && !Hit_clr && (hit_count[1:0] == 2'd3);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            hit_count <= 4'd0;
        end else if (Hit_clr) begin
            hit_count <= 4'd0;
        end else if (Hit_ld && hit_count != 4'd15) begin
            hit_count <= hit_count + 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            level <= 2'd0;
        end else if (Lvl_clr) begin
            level <= 2'd0;
        end else if (lvl_inc && level != 2'd3) begin
            level <= level + 2'd1;
        end
    end

    always_comb begin
        p1_win    = (P1_score == WIN_VAL);
        p2_win    = (P2_score == WIN_VAL);
        game_over = p1_win || p2_win;
        winner    = p2_win;
        // Simultaneous loads are contradictory, so neither player scores.
        p1_inc    = P1_ld && !P2_ld && !game_over;
        p2_inc    = P2_ld && !P1_ld && !game_over;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            P1_score <= 4'd0;
        end else if (P1_clr) begin
            P1_score <= 4'd0;
        end else if (p1_inc) begin
            P1_score <= P1_score + 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            P2_score <= 4'd0;
        end else if (P2_clr) begin
            P2_score <= 4'd0;
        end else if (p2_inc) begin
            P2_score <= P2_score + 4'd1;
        end
    end

endmodule

// File: doc/pong_datapath.md
PONG_DATAPATH -- requirements
Module: pong_datapath

Interface
REQ-001 Parameter T5_MAX, default 5: T5 serve/delay timer length in clock cycles (legal range 1..65535).
REQ-002 Parameter T20_BASE, default 20: ball-step period in cycles at level 0 (legal range 8..65535).
REQ-003 Parameter WIN_SCORE, default 7: score that ends a game (legal range 1..15).
REQ-004 Clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Rst  in  1  synchronous, active-low reset; sampled on the rising edge of Clk.
REQ-006 T5_en  in  1  T5 timer count enable, from the controller.
REQ-007 T5_rst  in  1  T5 timer clear, from the controller.
REQ-008 T20_en  in  1  ball-step timer count enable.
REQ-009 T20_rst  in  1  ball-step timer clear.
REQ-010 Hit_ld  in  1  one-cycle strobe: a paddle returned the ball.
REQ-011 Hit_clr  in  1  clear the hit counter.
REQ-012 Lvl_clr  in  1  clear the speed level.
REQ-013 P1_ld / P1_clr  in  1 each  increment / clear player-1 score.
REQ-014 P2_ld / P2_clr  in  1 each  increment / clear player-2 score.
REQ-015 T5_in  out  1  T5 expired; level signal returned to the controller.
REQ-016 T20_tick  out  1  one-cycle ball-step pulse.
REQ-017 hit_count  out  4  returns since last Hit_clr.
REQ-018 level  out  2  current speed level, 0..3.
REQ-019 P1_score / P2_score  out  4 each  player scores.
REQ-020 game_over  out  1  either score equals WIN_SCORE.
REQ-021 winner  out  1  0 = player 1 won, 1 = player 2 won; valid only while game_over=1, else 0.

Function
REQ-022 T5 counter: 16 bits; T5_rst=1 -> count 0, T5_in 0 next cycle, regardless of T5_en.
REQ-023 T5_rst=0 and T5_en=1 -> count increments by 1, saturating at T5_MAX; T5_en=0 -> count holds.
REQ-024 T5_in is registered, equal to (count==T5_MAX); with T5_en held after a clear, T5_in rises on the T5_MAX-th enabled edge and stays high until T5_rst.
REQ-025 Step period P = T20_BASE >> level (level 0..3 gives BASE, BASE/2, BASE/4, BASE/8).
REQ-026 T20 counter: 16 bits; T20_rst=1 -> count 0, T20_tick 0, with priority over T20_en.
REQ-027 T20_en=1: if count >= P-1 then count <= 0 and T20_tick=1 for exactly that cycle, else count+1 and T20_tick=0; T20_en=0 -> hold count, T20_tick=0.
REQ-028 A level change mid-period takes effect immediately; the ">=" compare guarantees a tick within one cycle when count already exceeds the new P-1.
REQ-029 Hit_clr=1 -> hit_count 0, Hit_ld ignored that cycle.
REQ-030 Hit_ld=1 (no Hit_clr) -> hit_count+1, saturating at 15.
REQ-031 Level increment: on an accepted Hit_ld with hit_count[1:0]==3 (every 4th return) level+1, saturating at 3.
REQ-032 Lvl_clr=1 -> level 0, overriding any same-cycle increment.
REQ-033 Score registers: Px_clr=1 -> Px_score 0, Px_ld ignored; clears are independent per player.
REQ-034 Px_ld=1 -> Px_score+1 only if game_over=0.
REQ-035 P1_ld and P2_ld both 1 in the same cycle is illegal; both are ignored and scores hold.
REQ-036 game_over and winner are combinational from the score registers: winner=1 iff P2_score==WIN_SCORE.
REQ-037 Once game_over=1, scores freeze until the relevant Px_clr.

Reset
REQ-038 Rst=0 at a rising edge forces the following to 0 on that edge, overriding every other input: both timer counts, T5_in, T20_tick, hit_count, level, P1_score, P2_score.
REQ-039 game_over and winner consequently read 0 after reset.
REQ-040 Reset asserted mid-count or mid-game abandons all state; there is no retained history.

Verification
REQ-041 T5: Rst high, T5_rst 1 cycle, then T5_en=1 -> T5_in rises on the 5th enabled edge and holds; T5_rst pulse -> T5_in 0 next cycle.
REQ-042 T20 at level 0: T20_en held -> T20_tick pulses every 20 cycles, each 1 cycle wide; after 4 Hit_ld strobes (level=1) period becomes 10.
REQ-043 Level: 16 Hit_ld strobes -> level saturates at 3, hit_count=15 after the 17th strobe; Hit_ld together with Hit_clr -> hit_count 0; Lvl_clr -> level 0.
REQ-044 Scoring: 7 P2_ld strobes -> P2_score=7, game_over=1, winner=1; an 8th P2_ld or a P1_ld leaves scores unchanged; P2_clr -> game_over 0.
REQ-045 Simultaneous P1_ld and P2_ld -> both scores unchanged.
REQ-046 Mid-game reset: scores 3/2, level 2, T20 running, Rst=0 for one edge -> all outputs 0 on the next cycle.
